// File: rtl/wb_master_arbiter_if.sv
// Pipelined Wishbone bus bundle shared by the arbiter's two upstream ports
// and its single downstream port.
//   master modport: the side that drives cyc/stb/addr (a bus master).
//   slave  modport: the side that answers with ack/err/stall/rdata.
// The downstream slave has no err line, so err is absent from the master modport.
interface wb_master_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();
    logic              cyc;
    logic              stb;
    logic              we;
    logic [AW-1:0]     addr;
    logic [DW-1:0]     wdata;
    logic [DW/8-1:0]   sel;
    logic              ack;
    logic              err;
    logic              stall;
    logic [DW-1:0]     rdata;

    modport master (
        output cyc, stb, we, addr, wdata, sel,
        input  ack, stall, rdata
    );

    modport slave (
        input  cyc, stb, we, addr, wdata, sel,
        output ack, err, stall, rdata
    );
endinterface

// File: rtl/wb_master_arbiter.sv
// Two-master to one-slave pipelined Wishbone arbiter.
// m0 (CPU core) and m1 (UART-bridge DMA) share the slave port s.
// - Round-robin grant; the owner keeps the bus until it drops cyc.
// - Handover always passes through one IDLE cycle.
// - A per-transaction ack watchdog aborts a hung transfer:
//   the owner gets a one-cycle err, the slave strobe is withdrawn, and the
//   master stays locked out until it drops cyc.
module wb_master_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255,
    parameter int TW      = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    wb_master_arbiter_if.slave   m0,
    wb_master_arbiter_if.slave   m1,
    wb_master_arbiter_if.master  s,
    output logic [1:0]           o_grant,
    output logic [7:0]           o_timeout_cnt
);

    localparam logic [TW-1:0] WD_LIMIT = TW'(TIMEOUT);
    localparam logic [TW-1:0] WD_MAX   = {TW{1'b1}};
    localparam int            PW       = 4;
    localparam logic [PW-1:0] PEND_MAX = {PW{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    state_t          state_r, state_s;
    logic            last_r, last_s;
    logic            lock0_r, lock0_s;
    logic            lock1_r, lock1_s;
    logic [TW-1:0]   wd_cnt_r, wd_cnt_s;
    logic [PW-1:0]   pend_r, pend_s;
    logic [7:0]      tcnt_r, tcnt_s;
    logic [1:0]      grant_r, grant_s;

    logic            owning_s;
    logic            owner_cyc_s;
    logic            owner_stb_s;
    logic            abort_s;
    logic            accept_s;
    logic            elig0_s;
    logic            elig1_s;

    // Current owner's request lines, abort detection and eligibility of both masters
    always_comb begin
        owning_s    = 1'b0;
        owner_cyc_s = 1'b0;
        owner_stb_s = 1'b0;
        case (state_r)
            OWN0: begin
                owning_s    = 1'b1;
                owner_cyc_s = m0.cyc;
                owner_stb_s = m0.stb;
            end
            OWN1: begin
                owning_s    = 1'b1;
                owner_cyc_s = m1.cyc;
                owner_stb_s = m1.stb;
            end
            default: begin
                owning_s    = 1'b0;
                owner_cyc_s = 1'b0;
                owner_stb_s = 1'b0;
            end
        endcase
        // The abort cycle is the one where the watchdog already holds the limit.
        abort_s  = owning_s && owner_cyc_s && (wd_cnt_r == WD_LIMIT);
        // A beat is accepted when it reaches the slave and the slave does not stall it.
        accept_s = owning_s && owner_stb_s && !abort_s && !s.stall;
        elig0_s  = m0.cyc && !lock0_r;
        elig1_s  = m1.cyc && !lock1_r;
    end

    // Next-state logic: arbitration, release, watchdog, lockout and abort counter
    always_comb begin
        state_s  = state_r;
        last_s   = last_r;
        wd_cnt_s = wd_cnt_r;
        pend_s   = pend_r;
        tcnt_s   = tcnt_r;
        // A lock is cleared by the first cycle in which the master drops cyc.
        if (m0.cyc) begin
            lock0_s = lock0_r;
        end else begin
            lock0_s = 1'b0;
        end
        if (m1.cyc) begin
            lock1_s = lock1_r;
        end else begin
            lock1_s = 1'b0;
        end

        case (state_r)
            IDLE: begin
                wd_cnt_s = {TW{1'b0}};
                pend_s   = {PW{1'b0}};
                if (elig0_s && elig1_s) begin
                    // Tie: the master that did not own the bus last wins.
                    if (last_r) begin
                        state_s = OWN0;
                    end else begin
                        state_s = OWN1;
                    end
                end else if (elig0_s) begin
                    state_s = OWN0;
                end else if (elig1_s) begin
                    state_s = OWN1;
                end else begin
                    state_s = IDLE;
                end
            end
            OWN0, OWN1: begin
                if (!owner_cyc_s) begin
                    // Normal release; the other master can only win after an IDLE cycle.
                    state_s  = IDLE;
                    last_s   = (state_r == OWN1);
                    wd_cnt_s = {TW{1'b0}};
                    pend_s   = {PW{1'b0}};
                end else if (abort_s) begin
                    state_s  = IDLE;
                    last_s   = (state_r == OWN1);
                    wd_cnt_s = {TW{1'b0}};
                    pend_s   = {PW{1'b0}};
                    if (state_r == OWN0) begin
                        lock0_s = 1'b1;
                    end else begin
                        lock1_s = 1'b1;
                    end
                    if (tcnt_r == 8'hFF) begin
                        tcnt_s = tcnt_r;
                    end else begin
                        tcnt_s = tcnt_r + 8'd1;
                    end
                end else begin
                    // Track accepted-but-unacked beats to know if a request is outstanding.
                    case ({accept_s, s.ack})
                        2'b10: begin
                            if (pend_r == PEND_MAX) begin
                                pend_s = pend_r;
                            end else begin
                                pend_s = pend_r + {{(PW-1){1'b0}}, 1'b1};
                            end
                        end
                        2'b01: begin
                            if (pend_r == {PW{1'b0}}) begin
                                pend_s = pend_r;
                            end else begin
                                pend_s = pend_r - {{(PW-1){1'b0}}, 1'b1};
                            end
                        end
                        default: pend_s = pend_r;
                    endcase
                    if (s.ack) begin
                        wd_cnt_s = {TW{1'b0}};
                    end else if (!owner_stb_s && (pend_r == {PW{1'b0}})) begin
                        wd_cnt_s = {TW{1'b0}};
                    end else if (wd_cnt_r == WD_MAX) begin
                        wd_cnt_s = wd_cnt_r;
                    end else begin
                        wd_cnt_s = wd_cnt_r + {{(TW-1){1'b0}}, 1'b1};
                    end
                end
            end
            default: begin
                state_s  = IDLE;
                wd_cnt_s = {TW{1'b0}};
                pend_s   = {PW{1'b0}};
            end
        endcase

        grant_s = {(state_s == OWN1), (state_s == OWN0)};
    end

    // State and counter registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r  <= IDLE;
            last_r   <= 1'b1;
            lock0_r  <= 1'b0;
            lock1_r  <= 1'b0;
            wd_cnt_r <= {TW{1'b0}};
            pend_r   <= {PW{1'b0}};
            tcnt_r   <= 8'd0;
            grant_r  <= 2'b00;
        end else begin
            state_r  <= state_s;
            last_r   <= last_s;
            lock0_r  <= lock0_s;
            lock1_r  <= lock1_s;
            wd_cnt_r <= wd_cnt_s;
            pend_r   <= pend_s;
            tcnt_r   <= tcnt_s;
            grant_r  <= grant_s;
        end
    end

    // Bus steering: slave side follows the owner, non-owner sees stall with no response
    always_comb begin
        s.cyc    = 1'b0;
        s.stb    = 1'b0;
        s.we     = 1'b0;
        s.addr   = {AW{1'b0}};
        s.wdata  = {DW{1'b0}};
        s.sel    = {(DW/8){1'b0}};
        m0.ack   = 1'b0;
        m0.err   = 1'b0;
        m0.stall = 1'b1;
        m0.rdata = {DW{1'b0}};
        m1.ack   = 1'b0;
        m1.err   = 1'b0;
        m1.stall = 1'b1;
        m1.rdata = {DW{1'b0}};
        if (i_rst) begin
            // An in-flight transfer is dropped silently: bus stays at its idle values.
            s.cyc = 1'b0;
        end else begin
            case (state_r)
                OWN0: begin
                    s.cyc    = m0.cyc && !abort_s;
                    s.stb    = m0.stb && !abort_s;
                    s.we     = m0.we;
                    s.addr   = m0.addr;
                    s.wdata  = m0.wdata;
                    s.sel    = m0.sel;
                    m0.ack   = s.ack && !abort_s;
                    m0.err   = abort_s;
                    m0.stall = s.stall;
                    m0.rdata = s.rdata;
                end
                OWN1: begin
                    s.cyc    = m1.cyc && !abort_s;
                    s.stb    = m1.stb && !abort_s;
                    s.we     = m1.we;
                    s.addr   = m1.addr;
                    s.wdata  = m1.wdata;
                    s.sel    = m1.sel;
                    m1.ack   = s.ack && !abort_s;
                    m1.err   = abort_s;
                    m1.stall = s.stall;
                    m1.rdata = s.rdata;
                end
                default: begin
                    s.cyc = 1'b0;
                end
            endcase
        end
    end

    assign o_grant       = grant_r;
    assign o_timeout_cnt = tcnt_r;

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Randomized bench for wb_master_arbiter. Two random Wishbone masters and a
// random (sometimes unresponsive) slave drive the arbiter; a transaction-level
// reference model (owner index, round-robin pointer, per-master lock flags,
// outstanding/watchdog counters) predicts every output each cycle.
module tb_wb_master_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int TO   = 8;
    localparam int TW   = 8;
    localparam int NCYC = 4000;

    logic        clk;
    logic        rst;
    logic [1:0]  grant;
    logic [7:0]  tcnt;

    int checks = 0;
    int errors = 0;

    wb_master_arbiter_if #(.AW(AW), .DW(DW)) m0 ();
    wb_master_arbiter_if #(.AW(AW), .DW(DW)) m1 ();
    wb_master_arbiter_if #(.AW(AW), .DW(DW)) s  ();

    wb_master_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO), .TW(TW)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .m0            (m0),
        .m1            (m1),
        .s             (s),
        .o_grant       (grant),
        .o_timeout_cnt (tcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // master stimulus state
    bit          mcyc[2], mstb[2], mwe[2];
    logic [31:0] maddr[2], mdat[2];
    logic [3:0]  msel[2];
    int          left[2], outst[2];
    bit          dead[2], took[2];
    // slave stimulus state
    bit          sack, sstall, deaf;
    logic [31:0] srd;
    int          sq;
    // reference model
    int          owner, last, wd, pend, aborts;
    bit          lock[2];
    int          n_owner, n_last, n_wd, n_pend, n_aborts;
    bit          n_lock[2];
    // expected outputs of the current cycle
    bit          live, ab, e_sstb, e_scyc;
    int          o;
    logic [1:0]  e_grant;
    bit          e_ack[2], e_err[2], e_stall[2];
    logic [31:0] e_rd[2];
    logic [31:0] obs_rd[2];
    bit          obs_ack[2], obs_err[2], obs_stall[2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_bus();
        m0.cyc = mcyc[0]; m0.stb = mstb[0]; m0.we = mwe[0];
        m0.addr = maddr[0]; m0.wdata = mdat[0]; m0.sel = msel[0];
        m1.cyc = mcyc[1]; m1.stb = mstb[1]; m1.we = mwe[1];
        m1.addr = maddr[1]; m1.wdata = mdat[1]; m1.sel = msel[1];
        s.ack = sack; s.stall = sstall; s.rdata = srd; s.err = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        for (int m = 0; m < 2; m++) begin
            mcyc[m] = 1'b0; mstb[m] = 1'b0; mwe[m] = 1'b0;
            maddr[m] = 32'd0; mdat[m] = 32'd0; msel[m] = 4'd0;
            left[m] = 0; outst[m] = 0; dead[m] = 1'b0; took[m] = 1'b0;
            lock[m] = 1'b0;
        end
        sack = 1'b0; sstall = 1'b0; deaf = 1'b0; srd = 32'd0; sq = 0;
        owner = -1; last = 1; wd = 0; pend = 0; aborts = 0;
        drive_bus();

        for (int cyc_i = 0; cyc_i < NCYC; cyc_i++) begin
            @(negedge clk);
            // ---- expected outputs for this cycle ----
            live = !rst && (owner >= 0);
            o    = (owner < 0) ? 0 : owner;
            ab   = live && mcyc[o] && (wd == TO);
            e_grant = (owner == 0) ? 2'b01 : ((owner == 1) ? 2'b10 : 2'b00);
            e_scyc  = live && mcyc[o] && !ab;
            e_sstb  = live && mstb[o] && !ab;
            check("grant", grant, e_grant);
            check("timeout_cnt", tcnt, aborts);
            check("s_cyc", s.cyc, e_scyc);
            check("s_stb", s.stb, e_sstb);
            check("s_we", s.we, live ? mwe[o] : 1'b0);
            check("s_addr", s.addr, live ? maddr[o] : 32'd0);
            check("s_wdata", s.wdata, live ? mdat[o] : 32'd0);
            check("s_sel", s.sel, live ? msel[o] : 4'd0);
            obs_ack[0] = m0.ack; obs_err[0] = m0.err; obs_stall[0] = m0.stall; obs_rd[0] = m0.rdata;
            obs_ack[1] = m1.ack; obs_err[1] = m1.err; obs_stall[1] = m1.stall; obs_rd[1] = m1.rdata;
            for (int m = 0; m < 2; m++) begin
                e_ack[m]   = live && (owner == m) && sack && !ab;
                e_err[m]   = live && (owner == m) && ab;
                e_stall[m] = (live && (owner == m)) ? sstall : 1'b1;
                e_rd[m]    = (live && (owner == m)) ? srd : 32'd0;
                check($sformatf("m%0d_ack", m), obs_ack[m], e_ack[m]);
                check($sformatf("m%0d_err", m), obs_err[m], e_err[m]);
                check($sformatf("m%0d_stall", m), obs_stall[m], e_stall[m]);
                check($sformatf("m%0d_rdata", m), obs_rd[m], e_rd[m]);
            end

            // ---- reference model: next transaction-level state ----
            n_owner = owner; n_last = last; n_wd = wd; n_pend = pend; n_aborts = aborts;
            for (int m = 0; m < 2; m++) n_lock[m] = mcyc[m] ? lock[m] : 1'b0;
            if (rst) begin
                n_owner = -1; n_last = 1; n_wd = 0; n_pend = 0; n_aborts = 0;
                n_lock[0] = 1'b0; n_lock[1] = 1'b0;
            end else if (owner < 0) begin
                n_wd = 0; n_pend = 0;
                if ((mcyc[0] && !lock[0]) && (mcyc[1] && !lock[1])) n_owner = 1 - last;
                else if (mcyc[0] && !lock[0]) n_owner = 0;
                else if (mcyc[1] && !lock[1]) n_owner = 1;
                else n_owner = -1;
            end else if (!mcyc[owner]) begin
                n_owner = -1; n_last = owner; n_wd = 0; n_pend = 0;
            end else if (ab) begin
                n_owner = -1; n_last = owner; n_wd = 0; n_pend = 0;
                n_lock[owner] = 1'b1;
                n_aborts = (aborts < 255) ? aborts + 1 : 255;
            end else begin
                n_pend = pend + ((e_sstb && !sstall) ? 1 : 0) - (sack ? 1 : 0);
                if (n_pend < 0) n_pend = 0;
                if (sack) n_wd = 0;
                else if (!mstb[owner] && pend == 0) n_wd = 0;
                else n_wd = wd + 1;
            end

            // ---- stimulus bookkeeping from what the masters/slave see ----
            for (int m = 0; m < 2; m++) begin
                took[m] = (owner == m) && e_sstb && !sstall;
                if (took[m]) begin
                    left[m]--;
                    outst[m]++;
                end
                if (e_ack[m] && outst[m] > 0) outst[m]--;
                if (e_err[m]) dead[m] = 1'b1;
            end
            if (e_sstb && !sstall) sq++;
            if (sack && sq > 0) sq--;

            @(posedge clk);
            #1;
            owner = n_owner; last = n_last; wd = n_wd; pend = n_pend; aborts = n_aborts;
            lock[0] = n_lock[0]; lock[1] = n_lock[1];

            // ---- new random inputs ----
            rst = (cyc_i < 2) || (cyc_i == 1000) || (cyc_i == 2000) || (cyc_i == 2001) || (cyc_i == 3000);
            for (int m = 0; m < 2; m++) begin
                if (!mcyc[m]) begin
                    mstb[m] = 1'b0;
                    if ($urandom_range(0, 99) < 30) begin
                        mcyc[m] = 1'b1; left[m] = $urandom_range(1, 4);
                        outst[m] = 0; dead[m] = 1'b0;
                    end
                end else if (dead[m]) begin
                    mstb[m] = 1'b0;
                    if ($urandom_range(0, 99) < 25) mcyc[m] = 1'b0;
                end else if ($urandom_range(0, 99) < 2) begin
                    mcyc[m] = 1'b0; mstb[m] = 1'b0;
                end else if (mstb[m] && !took[m]) begin
                    mstb[m] = 1'b1;
                end else if (left[m] > 0 && $urandom_range(0, 99) < 70) begin
                    mstb[m] = 1'b1; mwe[m] = 1'($urandom_range(0, 1));
                    maddr[m] = $urandom; mdat[m] = $urandom;
                    msel[m] = 4'($urandom_range(0, 15));
                end else begin
                    mstb[m] = 1'b0;
                    if (left[m] <= 0 && outst[m] == 0 && $urandom_range(0, 99) < 60) mcyc[m] = 1'b0;
                end
            end
            if (deaf) deaf = ($urandom_range(0, 99) >= 6);
            else      deaf = ($urandom_range(0, 99) < 2);
            sack   = !deaf && ((sq > 0 && $urandom_range(0, 99) < 50) || $urandom_range(0, 99) < 3);
            sstall = ($urandom_range(0, 99) < 25);
            srd    = $urandom;
            drive_bus();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_master_arbiter.md
Name: wb_master_arbiter

Overview:
- Two-master to one-slave Wishbone (pipelined) arbiter placed between the bus masters and WB_slave_arbiter.
- Master 0 is the picorv32_wb core; master 1 is the UART-bridge DMA engine.
- Shares the single slave port with round-robin grant and holds the grant for a whole cycle (cyc).
- A per-transaction ack watchdog ends hung transfers with an error pulse so a missing slave cannot lock the bus.

Parameters:
- AW, 32, address width
- DW, 32, data width (select width is DW/8)
- TIMEOUT, 255, cycles of stb-without-ack before abort; legal range 1..2^TW-1
- TW, 8, width of the watchdog counter

Ports:
- i_clk  in  1  system clock (s_sys_clk domain)
- i_rst  in  1  synchronous active-high reset
- i_m0_cyc, i_m0_stb, i_m0_we  in  1 each  master 0 cycle/strobe/write
- i_m0_addr  in  AW  master 0 address
- i_m0_data  in  DW  master 0 write data
- i_m0_sel  in  DW/8  master 0 byte select
- o_m0_ack, o_m0_err, o_m0_stall  out  1 each  master 0 response
- o_m0_data  out  DW  master 0 read data
- i_m1_* / o_m1_*  same set as master 0, for master 1
- o_s_cyc, o_s_stb, o_s_we  out  1 each  slave-side cycle/strobe/write
- o_s_addr  out  AW  slave-side address
- o_s_data  out  DW  slave-side write data
- o_s_sel  out  DW/8  slave-side byte select
- i_s_ack, i_s_stall  in  1 each  slave response
- i_s_data  in  DW  slave read data
- o_grant  out  2  one-hot current owner (bit0 = m0, bit1 = m1); 00 when idle
- o_timeout_cnt  out  8  saturating count of watchdog aborts

Behaviour:
- Reset: state IDLE; o_grant=00; last=1 (so m0 wins the first tie); wd_cnt=0; o_timeout_cnt=0; lock0=lock1=0. All outputs are 0 except o_mX_stall=1. A transfer in flight when reset asserts is dropped silently, with no ack or err.
- States: IDLE, OWN0, OWN1.
- Eligibility: master X is eligible when i_mX_cyc=1 and lockX=0.
- IDLE:
  - Only one master eligible -> go to its OWN state next cycle.
  - Both eligible -> grant the master != last.
  - Arbitration latency is 1 cycle: o_s_cyc is first asserted in the cycle after the request is seen.
- OWNx, slave side: o_s_cyc=i_mx_cyc and o_s_stb=i_mx_stb, both combinational. o_s_we/addr/data/sel are muxed from master x.
- OWNx, owner side: o_mx_ack=i_s_ack, o_mx_stall=i_s_stall, o_mx_data=i_s_data.
- OWNx, non-owner: ack=0, err=0, stall=1, data=0.
- Release: when i_mx_cyc=0 in OWNx, set last=x and go to IDLE next cycle. There is no same-cycle regrant; at least 1 idle cycle separates owners.
- Ownership persists across any number of stb/ack beats while cyc stays high.
- Watchdog, in OWNx:
  - Clears to 0 when i_s_ack=1, when i_mx_stb=0 with no outstanding request, or on state change.
  - Otherwise increments while a request is outstanding (stb issued and not yet acked).
  - When wd_cnt reaches TIMEOUT in cycle T (abort cycle):
    - o_mx_err=1 for exactly cycle T; o_mx_ack=0 in T even if i_s_ack arrives.
    - o_s_cyc=o_s_stb=0 from T onward.
    - lockx=1; o_timeout_cnt increments, saturating at 255; last=x; state goes to IDLE at T+1.
- Lock: lockx clears in the first cycle i_mx_cyc=0 is seen. A master that is aborted is not regranted until it drops cyc.
- i_s_ack while IDLE, or after an abort, is ignored and not forwarded.
- Simultaneous release by the owner and request by the other: the other master is granted 2 cycles later, via IDLE.
- Cycle sequence, cyc assert to grant: cycle 0 m0 cyc=1 seen in IDLE; cycle 1 o_grant=01, o_s_cyc=1.

Test Plan:
- Single master: m0 reads 0x0000_0100; slave acks 2 cycles after stb with data 0xDEADBEEF -> o_grant=01 one cycle after cyc, o_m0_data=0xDEADBEEF with o_m0_ack, m1 sees stall=1 and ack=0 throughout.
- Tie after reset: m0 and m1 raise cyc in the same cycle -> m0 granted first. After m0 drops cyc, exactly 1 idle cycle, then o_grant=10. Repeating the tie with last=0 grants m1.
- Burst hold: m1 issues 4 pipelined writes (sel=0xF, addr 0x0200_0000..0x0200_000C) while m0 requests -> o_grant stays 10 for all 4 acks; m0 is granted only after m1 cyc falls.
- Watchdog, TIMEOUT=8: m0 strobes and the slave never acks -> o_m0_err pulses 1 cycle at wd_cnt=8, o_s_cyc=0 from that cycle, o_timeout_cnt=1. With m0 cyc still 1, m0 is not regranted; m1 is granted if requesting. After m0 drops and reraises cyc, it is granted again.
- Late ack after abort: slave acks 1 cycle after the err cycle -> o_m0_ack and o_m1_ack both remain 0.
- Reset mid-transfer: assert i_rst while OWN1 with stb outstanding -> next cycle o_grant=00, o_s_cyc=0, o_timeout_cnt=0, no ack or err. Tie afterwards grants m0.
